// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 64-bit in-order pipeline.
// Holds the MEM/WB register layout and the memory-access FSM states.
package pipeline_pkg;

  localparam int XLEN = 64;
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic [XLEN-1:0] read_data;
    logic [XLEN-1:0] alu_result;
    logic [4:0]      rd;
  } mem_wb_t;

endpackage

// File: rtl/mem_access_fsm.sv
// Tracks one outstanding data-memory access: stall while waiting, abort on timeout.
// Zero-wait accesses never stall; mem_fault pulses the cycle after an abort.
module mem_access_fsm
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_op_i,
  input  logic dmem_ready_i,
  output logic done_o,
  output logic abort_o,
  output logic stall_o,
  output logic mem_fault_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= abort_o;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op_i && !dmem_ready_i) state_d = WAIT;
      WAIT:    if (done_o || abort_o) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Counter only runs while staying in WAIT; entry and IDLE both see zero.
    wait_cnt_d = (state_q == WAIT && state_d == WAIT) ? wait_cnt_q + 1'b1 : '0;
  end

  always_comb begin
    done_o      = mem_op_i & ~reset & dmem_ready_i;
    abort_o     = (state_q == WAIT) & (wait_cnt_q == CNT_LAST) & ~dmem_ready_i;
    stall_o     = mem_op_i & ~done_o & ~abort_o & ~reset;
    mem_fault_o = mem_fault_q;
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register: drives the dmem bus, stalls upstream
// while an access is outstanding, and loads a bubble on stall or timeout.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWrite_in,
  input  logic            MemtoReg_in,
  input  logic            MemWrite_in,
  input  logic [XLEN-1:0] AluOut_in,
  input  logic [XLEN-1:0] StoreData_in,
  input  logic [4:0]      Rd_in,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_out,
  output logic            mem_fault,
  output logic            RegWrite_Out,
  output logic            MemtoReg_Out,
  output logic [XLEN-1:0] ReadData_Out,
  output logic [XLEN-1:0] AluResult_Out,
  output logic [4:0]      Rd_out
);

  logic    mem_op, done, abort, stall;
  mem_wb_t wb_q, wb_d;

  assign mem_op     = MemtoReg_in | MemWrite_in;
  assign dmem_req   = mem_op & ~reset;
  // A load+store encoding resolves to a store.
  assign dmem_we    = MemWrite_in;
  assign dmem_addr  = AluOut_in;
  assign dmem_wdata = StoreData_in;
  assign stall_out  = stall;

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .mem_op_i    (mem_op),
    .dmem_ready_i(dmem_ready),
    .done_o      (done),
    .abort_o     (abort),
    .stall_o     (stall),
    .mem_fault_o (mem_fault)
  );

  always_comb begin
    wb_d = '0;
    if (!(stall || abort)) begin
      wb_d.reg_write  = RegWrite_in & ~MemWrite_in & (Rd_in != REG_ZERO);
      wb_d.mem_to_reg = MemtoReg_in & ~MemWrite_in;
      wb_d.alu_result = AluOut_in;
      wb_d.rd         = Rd_in;
      wb_d.read_data  = (done && !dmem_we) ? dmem_rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) wb_q <= '0;
    else       wb_q <= wb_d;
  end

  assign RegWrite_Out  = wb_q.reg_write;
  assign MemtoReg_Out  = wb_q.mem_to_reg;
  assign ReadData_Out  = wb_q.read_data;
  assign AluResult_Out = wb_q.alu_result;
  assign Rd_out        = wb_q.rd;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed plan steps followed by randomized instruction traffic, both checked
// against a cycle-level model built from elapsed-wait-time rules.
module tb_mem_wb_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite_in, MemtoReg_in, MemWrite_in;
  logic [63:0] AluOut_in, StoreData_in;
  logic [4:0]  Rd_in;
  logic        dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic        dmem_ready;
  logic [63:0] dmem_rdata;
  logic        stall_out, mem_fault;
  logic        RegWrite_Out, MemtoReg_Out;
  logic [63:0] ReadData_Out, AluResult_Out;
  logic [4:0]  Rd_out;

  always #5 clk = ~clk;

  mem_wb_stage #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
    .AluOut_in(AluOut_in), .StoreData_in(StoreData_in), .Rd_in(Rd_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stall_out(stall_out), .mem_fault(mem_fault),
    .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
    .ReadData_Out(ReadData_Out), .AluResult_Out(AluResult_Out), .Rd_out(Rd_out)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: an access is "busy" after its issue cycle; elapsed counts edges since issue.
  bit          m_busy = 0;
  int          m_elapsed = 0;
  logic        m_fault = 0;
  logic        m_rw = 0, m_mtr = 0;
  logic [63:0] m_rdata = '0, m_alu = '0;
  logic [4:0]  m_rd = '0;
  logic        e_stall = 0;
  logic        obs_stall, obs_req, obs_we;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rw, input logic mr, input logic mw,
                        input logic [63:0] alu, input logic [63:0] sd, input logic [4:0] rd);
    RegWrite_in = rw; MemtoReg_in = mr; MemWrite_in = mw;
    AluOut_in = alu; StoreData_in = sd; Rd_in = rd;
  endtask

  task automatic tick();
    logic memop, e_req, e_done, e_abort;
    @(negedge clk);
    memop   = MemtoReg_in | MemWrite_in;
    e_req   = memop & ~reset;
    e_done  = e_req & dmem_ready;
    e_abort = m_busy && (m_elapsed == T) && !dmem_ready;
    e_stall = memop & ~e_done & ~e_abort & ~reset;
    obs_stall = stall_out; obs_req = dmem_req; obs_we = dmem_we;
    chk("bus", {dmem_req, dmem_we, dmem_addr, dmem_wdata},
        {e_req, MemWrite_in, AluOut_in, StoreData_in});
    chk("stall", stall_out, e_stall);
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_elapsed = 0; m_fault = 0;
      m_rw = 0; m_mtr = 0; m_rdata = '0; m_alu = '0; m_rd = '0;
    end else begin
      m_fault = e_abort;
      if (e_stall || e_abort) begin
        m_rw = 0; m_mtr = 0; m_rdata = '0; m_alu = '0; m_rd = '0;
      end else begin
        m_rw    = RegWrite_in & ~MemWrite_in & (Rd_in != 0);
        m_mtr   = MemtoReg_in & ~MemWrite_in;
        m_alu   = AluOut_in;
        m_rd    = Rd_in;
        m_rdata = (e_done && !MemWrite_in) ? dmem_rdata : 64'd0;
      end
      if (m_busy) begin
        if (e_done || e_abort) m_busy = 0;
        else m_elapsed++;
      end else if (memop && !dmem_ready) begin
        m_busy = 1; m_elapsed = 1;
      end
    end
    #1;
    chk("memwb", {RegWrite_Out, MemtoReg_Out, ReadData_Out, AluResult_Out, Rd_out},
        {m_rw, m_mtr, m_rdata, m_alu, m_rd});
    chk("fault", mem_fault, m_fault);
  endtask

  initial begin
    int sc, rc, fc, kind;
    reset = 1; dmem_ready = 0; dmem_rdata = '0;
    set_in(0, 0, 0, '0, '0, '0);
    tick(); tick();
    chk("reset_outs", {RegWrite_Out, MemtoReg_Out, ReadData_Out, AluResult_Out, Rd_out, mem_fault}, '0);
    reset = 0;

    // ALU op
    set_in(1, 0, 0, 64'h1234, 64'h0, 5'd5);
    tick();
    chk("alu_out", {RegWrite_Out, AluResult_Out, Rd_out, obs_stall, obs_req},
        {1'b1, 64'h1234, 5'd5, 1'b0, 1'b0});

    // Zero-wait load
    set_in(1, 1, 0, 64'h40, 64'h0, 5'd7);
    dmem_ready = 1; dmem_rdata = 64'hDEADBEEF;
    tick();
    chk("zw_load", {obs_stall, ReadData_Out, MemtoReg_Out, Rd_out, RegWrite_Out},
        {1'b0, 64'hDEADBEEF, 1'b1, 5'd7, 1'b1});

    // 3-wait store, ready on the 4th cycle
    set_in(0, 0, 1, 64'h100, 64'hAA, 5'd3);
    dmem_ready = 0; sc = 0; rc = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_ready = 1;
      tick();
      sc += int'(obs_stall);
      rc += int'(obs_req & obs_we);
      chk("st_rw", RegWrite_Out, 1'b0);
    end
    chk("st_stalls", sc, 3);
    chk("st_reqs", rc, 4);

    // Timeout on a load
    set_in(1, 1, 0, 64'h200, 64'h0, 5'd9);
    dmem_ready = 0; sc = 0; fc = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      sc += int'(obs_stall);
      fc += int'(mem_fault);
      chk("to_bubble", {RegWrite_Out, MemtoReg_Out, Rd_out}, '0);
    end
    set_in(0, 0, 0, 64'h0, 64'h0, 5'd0);
    tick();
    fc += int'(mem_fault);
    chk("to_stalls", sc, 4);
    chk("to_fault_pulses", fc, 1);

    // Reset during an outstanding load
    set_in(1, 1, 0, 64'h300, 64'h0, 5'd11);
    tick(); tick(); tick();
    reset = 1;
    tick();
    chk("rst_req_stall", {obs_req, obs_stall}, '0);
    chk("rst_outs", {RegWrite_Out, MemtoReg_Out, ReadData_Out, AluResult_Out, Rd_out, mem_fault}, '0);
    reset = 0;
    set_in(0, 0, 0, 64'h0, 64'h0, 5'd0);
    dmem_ready = 1; dmem_rdata = 64'h55;
    tick();
    chk("stray_ready", {RegWrite_Out, MemtoReg_Out, ReadData_Out, AluResult_Out, Rd_out}, '0);

    // Write to x0
    dmem_ready = 0;
    set_in(1, 0, 0, 64'h5, 64'h0, 5'd0);
    tick();
    chk("x0", {RegWrite_Out, Rd_out}, '0);

    // Load+store together behaves as a store
    set_in(1, 1, 1, 64'h80, 64'h77, 5'd4);
    dmem_ready = 1;
    tick();
    chk("both_store", {obs_we, RegWrite_Out, MemtoReg_Out, ReadData_Out}, {1'b1, 1'b0, 1'b0, 64'h0});

    // Random traffic; the instruction is held while the model predicts a stall
    for (int n = 0; n < 2000; n++) begin
      if (!e_stall) begin
        kind = int'($urandom_range(0, 4));
        set_in($urandom_range(0, 1) == 1, kind == 2 || kind == 4, kind == 3 || kind == 4,
               {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
        if (kind == 0) begin
          MemtoReg_in = 0; MemWrite_in = 0;
        end
      end
      dmem_ready = $urandom_range(0, 2) == 0;
      dmem_rdata = {$urandom, $urandom};
      reset      = $urandom_range(0, 59) == 0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register of the 64-bit in-order pipeline.
- Sits directly downstream of the EX/MEM register and consumes its control bits (RegWrite, MemtoReg, MemWrite), ALU result, store data and Rd.
- Drives the data-memory request/ready bus and generates a stall back to EX/MEM and earlier stages while a memory access is outstanding.
- Presents registered write-back data to the WB mux.

Parameters:
- XLEN, 64, datapath and address width.
- TIMEOUT_CYCLES, 16, maximum wait cycles for dmem_ready before aborting the access (must be >= 1).

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite_in  input  1  from EX/MEM: write-back enable.
- MemtoReg_in  input  1  from EX/MEM: load; WB takes memory data.
- MemWrite_in  input  1  from EX/MEM: store.
- AluOut_in  input  XLEN  from EX/MEM: ALU result / memory address.
- StoreData_in  input  XLEN  from EX/MEM: store data.
- Rd_in  input  5  from EX/MEM: destination register.
- dmem_req  output  1  memory request valid.
- dmem_we  output  1  1 = store, 0 = load.
- dmem_addr  output  XLEN  equals AluOut_in.
- dmem_wdata  output  XLEN  equals StoreData_in.
- dmem_ready  input  1  memory completes the access this cycle.
- dmem_rdata  input  XLEN  load data; valid when dmem_ready = 1.
- stall_out  output  1  hold EX/MEM and upstream registers this cycle.
- mem_fault  output  1  one-cycle pulse: access timed out.
- RegWrite_Out  output  1  to WB.
- MemtoReg_Out  output  1  to WB.
- ReadData_Out  output  XLEN  loaded data to WB.
- AluResult_Out  output  XLEN  ALU result to WB.
- Rd_out  output  5  to WB.

Behaviour:
- mem_op = MemtoReg_in | MemWrite_in.
  - If both are set, the access is treated as a store: dmem_we = 1 and the MEM/WB RegWrite is forced to 0.
- FSM states:
  - IDLE: no access outstanding.
  - WAIT: access issued, dmem_ready not yet seen.
- dmem_req = mem_op & ~reset, combinational, asserted in both IDLE and WAIT. dmem_addr, dmem_we and dmem_wdata are combinational from the inputs.
- done = dmem_req & dmem_ready. abort = (state == WAIT) & (wait_cnt == TIMEOUT_CYCLES - 1) & ~dmem_ready.
- stall_out = mem_op & ~done & ~abort & ~reset.
  - A zero-wait memory (ready in the first cycle) produces no stall.
- Transitions:
  - IDLE -> WAIT when mem_op & ~dmem_ready.
  - WAIT -> IDLE on done or abort.
  - WAIT holds otherwise.
  - IDLE stays IDLE when there is no mem_op or on done.
- wait_cnt:
  - Clears on entry to WAIT and in IDLE.
  - Increments each cycle in WAIT.
  - Width is ceil(log2(TIMEOUT_CYCLES + 1)).
- MEM/WB register update, every edge:
  - If stall_out = 1 or abort = 1: load a bubble (RegWrite_Out = 0, MemtoReg_Out = 0, Rd_out = 0, data fields 0).
  - Otherwise capture the inputs: RegWrite_Out = RegWrite_in & ~MemWrite_in & (Rd_in != 0); MemtoReg_Out = MemtoReg_in & ~MemWrite_in; AluResult_Out = AluOut_in; Rd_out = Rd_in; ReadData_Out = dmem_rdata when done & ~dmem_we, else 0.
- mem_fault: registered 1 in the cycle after abort, 0 otherwise.
- Latency: one cycle from input to MEM/WB output for non-memory ops and zero-wait accesses; N + 1 cycles for an access whose ready arrives N cycles after issue.
- Reset, including mid-access:
  - All outputs go to 0, state -> IDLE, wait_cnt -> 0, mem_fault -> 0.
  - dmem_req and stall_out are 0 in every cycle where reset = 1.
  - An outstanding access is abandoned, and a late dmem_ready after reset is ignored unless a new mem_op is present.
- dmem_ready while dmem_req = 0 is ignored.

Decomposition:
- Shared package pipeline_pkg holds:
  - XLEN.
  - The mem_state_t enum {IDLE, WAIT}.
  - A mem_wb_t struct for the MEM/WB register fields.
  - The localparam REG_ZERO = 5'd0.
- Natural sub-module: mem_access_fsm, which owns state, wait_cnt, stall_out, abort and mem_fault. The top level holds the MEM/WB register and the bus wiring.

Test Plan:
- ALU op: RegWrite_in = 1, AluOut_in = 64'h1234, Rd_in = 5 -> next edge RegWrite_Out = 1, AluResult_Out = 64'h1234, Rd_out = 5, stall_out never 1, dmem_req = 0.
- Zero-wait load: MemtoReg_in = 1, RegWrite_in = 1, Rd_in = 7, dmem_ready = 1 and dmem_rdata = 64'hDEADBEEF same cycle -> no stall; next edge ReadData_Out = 64'hDEADBEEF, MemtoReg_Out = 1, Rd_out = 7.
- 3-wait store: MemWrite_in = 1, AluOut_in = 64'h100, StoreData_in = 64'hAA, ready on the 4th cycle -> dmem_req = 1 and dmem_we = 1 for 4 cycles, stall_out = 1 for 3 cycles, RegWrite_Out = 0 throughout.
- Timeout with TIMEOUT_CYCLES = 4: load with dmem_ready held 0 -> stall_out released after 4 WAIT cycles, MEM/WB holds a bubble, mem_fault pulses 1 for exactly one cycle, state returns to IDLE.
- Reset mid-access: load in WAIT for 2 cycles, then reset = 1 for 1 cycle -> dmem_req = 0 and stall_out = 0 that cycle, all outputs 0 after the edge; a stray dmem_ready afterwards with no mem_op changes nothing.
- x0 write: RegWrite_in = 1, Rd_in = 0, AluOut_in = 64'h5 -> RegWrite_Out = 0, Rd_out = 0.
